stream_demux_1to2: RTL and testbench
====================================

// Module: stream_demux_1to2
// PURPOSE
//  Registered 1-to-2 demultiplexer: steers one valid/ready data stream to one of two
//  destination streams under a per-beat select bit. Opposite direction of the 2:1 mux
//  used on CPU datapaths; it routes results/requests (e.g. writeback vs. store path)
//  to two consumers with independent back-pressure. One 2-entry buffer per output.
// PARAMETERS
//  WIDTH   32  data bits per beat
//  CNT_W   16  width of per-output beat counters (STREAM_DEMUX_STATS_EN only)
// PORTS
//  clk         in   1      single clock, all logic on rising edge
//  rst         in   1      synchronous, active-high reset
//  in_valid    in   1      input beat present
//  in_ready    out  1      input beat accepted when in_valid && in_ready
//  in_sel      in   1      0 -> output 0, 1 -> output 1; sampled with the beat
//  in_data     in   WIDTH  input payload
//  out0_valid  out  1      output 0 beat present
//  out0_ready  in   1      output 0 consumer accepts
//  out0_data   out  WIDTH  output 0 payload
//  out1_valid  out  1      output 1 beat present
//  out1_ready  in   1      output 1 consumer accepts
//  out1_data   out  WIDTH  output 1 payload
//  out0_cnt    out  CNT_W  beats delivered on output 0 (STREAM_DEMUX_STATS_EN only)
//  out1_cnt    out  CNT_W  beats delivered on output 1 (STREAM_DEMUX_STATS_EN only)
// BEHAVIOUR
//  - Reset: both buffers EMPTY, out0_valid=out1_valid=0, out*_data=0, counters=0.
//  - Per output buffer states: EMPTY(0) -> ONE(1) -> TWO(2); push on accepted beat with
//    matching in_sel, pop on outN_valid && outN_ready; push+pop same cycle keeps count.
//  - in_ready = (count of buffer selected by in_sel) < 2; derived from registered counts
//    only -- no combinational path out*_ready -> in_ready. in_ready may follow in_sel.
//  - Latency: beat accepted at edge k is on outN_data with outN_valid=1 from cycle k+1.
//  - outN_valid = (countN != 0); outN_data = head entry; stable while valid && !ready.
//  - Order preserved within each output; no ordering relation between outputs.
//  - Full throughput: one beat/cycle sustained into an output whose consumer holds ready=1.
//  - Full: selected buffer in TWO and not popping -> in_ready=0, beat held upstream; the
//    other output keeps draining. Pop from TWO in same cycle does not lift in_ready
//    that cycle (registered count).
//  - Empty + push + ready: beat still takes 1 cycle (no bypass).
//  - in_sel ignored when in_valid=0. Non-selected buffer never changes on a push.
//  - rst asserted mid-operation: buffered beats discarded, state as reset next cycle.
// CONFIGURATION
//  STREAM_DEMUX_STATS_EN defined: out0_cnt/out1_cnt ports present; each increments by 1
//  on its output handshake, wraps 2^CNT_W-1 -> 0, cleared by rst.
//  Not defined: counter ports and logic absent; datapath behaviour identical.
// STRUCTURE
//  - stream_demux_defs.vh: buffer depth constant (2), state encodings EMPTY/ONE/TWO,
//    select encodings SEL_OUT0=1'b0, SEL_OUT1=1'b1.
//  - Sub-module demux_skid_buf (2-entry FIFO with push/pop, count, head data),
//    instantiated once per output; top holds select/ready logic and counters.
// TESTING
//  1 Reset: hold rst 2 cycles with in_valid=1 -> out*_valid=0, in_ready=1 after release.
//  2 Steering: send 0xA5A5A5A5 sel=0 then 0x5A5A5A5A sel=1, both readys=1 -> each appears
//    one cycle after acceptance on correct output only, other output stays invalid.
//  3 Back-pressure: out0_ready=0, send 3 beats sel=0 -> beats 1,2 accepted, in_ready=0 on
//    3rd; out0_data stable =beat1; raise out0_ready -> beats 1,2,3 delivered in order.
//  4 Independence: out0 full and stalled, send sel=1 beats -> accepted every cycle,
//    delivered on out1 with 1-cycle latency.
//  5 Streaming: 100 back-to-back beats alternating sel, both readys=1 -> in_ready stays 1,
//    all beats delivered, per-output order intact.
//  6 Stats (STREAM_DEMUX_STATS_EN, CNT_W=4): 17 beats to out1 -> out1_cnt=1 (wrapped),
//    out0_cnt=0; rst mid-stream -> both counters 0 next cycle.

Source files
------------

// File: rtl/stream_demux_1to2_pkg.sv
// rtl/stream_demux_1to2_pkg.sv - shared constants and buffer state encoding for stream_demux_1to2
//
// Purpose: buffer depth, per-output buffer occupancy states and select encodings
//          used by stream_demux_1to2 and demux_skid_buf.
// Ports:   none (package).

package stream_demux_1to2_pkg;

    // Entries held by each per-output buffer.
    localparam logic [1:0] BUF_DEPTH = 2'd2;

    // Buffer occupancy doubles as the state encoding, so the state is the count.
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_e;

    localparam logic SEL_OUT0 = 1'b0;
    localparam logic SEL_OUT1 = 1'b1;

endpackage

// File: rtl/demux_skid_buf.sv
// rtl/demux_skid_buf.sv - 2-entry FIFO feeding one demux output
//
// Purpose: holds up to two beats for one destination; head entry drives the output.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push_i          write push_data_i this cycle (caller guarantees room)
//   push_data_i     beat to store
//   pop_i           head consumed this cycle (caller guarantees not empty)
//   count_o         registered occupancy 0..2
//   valid_o         head entry present
//   head_o          head entry payload

module demux_skid_buf
    import stream_demux_1to2_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [1:0]       count_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] head_o
);

    buf_state_e       state_q, state_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BUF_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    // Entries shift toward the head on pop, so the output is always head_q.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        unique case (state_q)
            BUF_EMPTY: begin
                if (push_i) begin
                    head_d  = push_data_i;
                    state_d = BUF_ONE;
                end
            end
            BUF_ONE: begin
                unique case ({push_i, pop_i})
                    2'b10: begin
                        tail_d  = push_data_i;
                        state_d = BUF_TWO;
                    end
                    2'b01:   state_d = BUF_EMPTY;
                    2'b11:   head_d  = push_data_i;
                    default: ;
                endcase
            end
            BUF_TWO: begin
                if (pop_i) begin
                    head_d = tail_q;
                    if (push_i) begin
                        tail_d = push_data_i;
                    end else begin
                        state_d = BUF_ONE;
                    end
                end
            end
            default: state_d = BUF_EMPTY;
        endcase
    end

    assign count_o = state_q;
    assign valid_o = (state_q != BUF_EMPTY);
    assign head_o  = head_q;

endmodule

// File: rtl/stream_demux_1to2.sv
// rtl/stream_demux_1to2.sv - registered 1-to-2 valid/ready stream demultiplexer
//
// Purpose: steers each input beat to output 0 or 1 by in_sel; each output has its
//          own 2-entry buffer so the two consumers back-pressure independently.
// Optional feature: STREAM_DEMUX_STATS_EN adds per-output delivered-beat counters.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   in_valid/in_ready/in_sel/in_data   input stream, in_sel picks the destination
//   out0_valid/out0_ready/out0_data    output 0 stream
//   out1_valid/out1_ready/out1_data    output 1 stream
//   out0_cnt/out1_cnt               wrapping delivered-beat counters (stats build only)

module stream_demux_1to2
    import stream_demux_1to2_pkg::*;
#(
    parameter int WIDTH = 32
`ifdef STREAM_DEMUX_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data
`ifdef STREAM_DEMUX_STATS_EN
    ,
    output logic [CNT_W-1:0] out0_cnt,
    output logic [CNT_W-1:0] out1_cnt
`endif
);

    logic [1:0] count0, count1, sel_count;
    logic       accept, push0, push1, pop0, pop1;

    // Ready comes only from registered occupancy: a same-cycle pop from a full
    // buffer does not open the input, which keeps out*_ready off the in_ready path.
    assign sel_count = (in_sel == SEL_OUT1) ? count1 : count0;
    assign in_ready  = (sel_count < BUF_DEPTH);
    assign accept    = in_valid && in_ready;
    assign push0     = accept && (in_sel == SEL_OUT0);
    assign push1     = accept && (in_sel == SEL_OUT1);
    assign pop0      = out0_valid && out0_ready;
    assign pop1      = out1_valid && out1_ready;

    demux_skid_buf #(.WIDTH(WIDTH)) u_buf0 (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push0),
        .push_data_i (in_data),
        .pop_i       (pop0),
        .count_o     (count0),
        .valid_o     (out0_valid),
        .head_o      (out0_data)
    );

    demux_skid_buf #(.WIDTH(WIDTH)) u_buf1 (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push1),
        .push_data_i (in_data),
        .pop_i       (pop1),
        .count_o     (count1),
        .valid_o     (out1_valid),
        .head_o      (out1_data)
    );

`ifdef STREAM_DEMUX_STATS_EN
    logic [CNT_W-1:0] out0_cnt_q, out1_cnt_q;

    // Counters wrap naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            out0_cnt_q <= '0;
            out1_cnt_q <= '0;
        end else begin
            if (pop0) out0_cnt_q <= out0_cnt_q + 1'b1;
            if (pop1) out1_cnt_q <= out1_cnt_q + 1'b1;
        end
    end

    assign out0_cnt = out0_cnt_q;
    assign out1_cnt = out1_cnt_q;
`endif

endmodule

// File: tb/tb_stream_demux_1to2.sv
// tb/tb_stream_demux_1to2.sv - scoreboard testbench for stream_demux_1to2

module tb_stream_demux_1to2;

    localparam int WIDTH = 32;
`ifdef STREAM_DEMUX_STATS_EN
    localparam int CNT_W = 4;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, in_ready, in_sel;
    logic [WIDTH-1:0] in_data;
    logic             out0_valid, out0_ready, out1_valid, out1_ready;
    logic [WIDTH-1:0] out0_data, out1_data;
`ifdef STREAM_DEMUX_STATS_EN
    logic [CNT_W-1:0] out0_cnt, out1_cnt;
    logic [CNT_W-1:0] cnt0_m, cnt1_m;
`endif

    always #5 clk = ~clk;

    stream_demux_1to2 #(
        .WIDTH (WIDTH)
`ifdef STREAM_DEMUX_STATS_EN
        ,
        .CNT_W (CNT_W)
`endif
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sel     (in_sel),
        .in_data    (in_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data)
`ifdef STREAM_DEMUX_STATS_EN
        ,
        .out0_cnt   (out0_cnt),
        .out1_cnt   (out1_cnt)
`endif
    );

    int checks = 0;
    int fails  = 0;
    int sent0 = 0, sent1 = 0, got0 = 0, got1 = 0;
    logic [WIDTH-1:0] q0[$];
    logic [WIDTH-1:0] q1[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Stimulus side of the scoreboard: a beat handshaken at the coming edge is
    // expected, in order, on the output its select names.
    always @(negedge clk) begin
        #1;
        if (!rst && in_valid && in_ready) begin
            if (in_sel) begin
                q1.push_back(in_data);
                sent1++;
            end else begin
                q0.push_back(in_data);
                sent0++;
            end
        end
    end

    // Monitor: the queues hold exactly what each buffer should hold right now.
    always @(negedge clk) begin
        if (rst) begin
            q0.delete();
            q1.delete();
`ifdef STREAM_DEMUX_STATS_EN
            cnt0_m = '0;
            cnt1_m = '0;
`endif
        end else begin
            check("in_ready", {63'b0, in_ready},
                  {63'b0, in_sel ? (q1.size() < 2) : (q0.size() < 2)});
            check("out0_valid", {63'b0, out0_valid}, {63'b0, q0.size() != 0});
            check("out1_valid", {63'b0, out1_valid}, {63'b0, q1.size() != 0});
            if (q0.size() != 0) check("out0_data", {32'b0, out0_data}, {32'b0, q0[0]});
            if (q1.size() != 0) check("out1_data", {32'b0, out1_data}, {32'b0, q1[0]});
`ifdef STREAM_DEMUX_STATS_EN
            check("out0_cnt", {{(64-CNT_W){1'b0}}, out0_cnt}, {{(64-CNT_W){1'b0}}, cnt0_m});
            check("out1_cnt", {{(64-CNT_W){1'b0}}, out1_cnt}, {{(64-CNT_W){1'b0}}, cnt1_m});
`endif
            if (out0_valid && out0_ready && q0.size() != 0) begin
                void'(q0.pop_front());
                got0++;
`ifdef STREAM_DEMUX_STATS_EN
                cnt0_m = cnt0_m + 1'b1;
`endif
            end
            if (out1_valid && out1_ready && q1.size() != 0) begin
                void'(q1.pop_front());
                got1++;
`ifdef STREAM_DEMUX_STATS_EN
                cnt1_m = cnt1_m + 1'b1;
`endif
            end
        end
    end

    // Called just after a rising edge; inputs hold through the next edge.
    task automatic drive(input logic v, input logic s, input logic [WIDTH-1:0] d,
                         input logic r0, input logic r1);
        in_valid   = v;
        in_sel     = s;
        in_data    = d;
        out0_ready = r0;
        out1_ready = r1;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 4; i++) drive(1'b0, 1'($urandom), $urandom, 1'b1, 1'b1);
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b1;
        in_sel     = 1'b0;
        in_data    = 32'hDEAD_BEEF;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("reset_in_ready", {63'b0, in_ready}, 64'd1);
        check("reset_out0_valid", {63'b0, out0_valid}, 64'd0);
        check("reset_out1_valid", {63'b0, out1_valid}, 64'd0);
        check("reset_out0_data", {32'b0, out0_data}, 64'd0);
        check("reset_out1_data", {32'b0, out1_data}, 64'd0);
        @(posedge clk);
        #1;

        // Steering
        drive(1'b1, 1'b0, 32'hA5A5_A5A5, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 32'h5A5A_5A5A, 1'b1, 1'b1);
        drain();

        // Back-pressure: third beat held until out0 drains
        drive(1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 32'h0000_0002, 1'b0, 1'b1);
        repeat (3) drive(1'b1, 1'b0, 32'h0000_0003, 1'b0, 1'b1);
        check("bp_in_ready_low", {63'b0, in_ready}, 64'd0);
        check("bp_head_stable", {32'b0, out0_data}, 64'd1);
        drive(1'b1, 1'b0, 32'h0000_0003, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 32'h0000_0003, 1'b1, 1'b1);
        drain();
        check("bp_delivered", got0, 4);

        // Independence: out0 full and stalled, out1 streams
        drive(1'b1, 1'b0, 32'h1111_0000, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 32'h1111_0001, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, 32'h2222_0000 + i, 1'b0, 1'b1);
        drain();
        check("indep_sent1", sent1, 7);

        // Streaming: 100 alternating beats
        for (int i = 0; i < 100; i++) drive(1'b1, 1'(i % 2), $urandom, 1'b1, 1'b1);
        drain();
        check("stream_all_delivered0", got0, sent0);
        check("stream_all_delivered1", got1, sent1);

        // Random traffic with a mid-stream reset
        for (int i = 0; i < 500; i++) begin
            if (i == 250) rst = 1'b1;
            drive(($urandom % 4) != 0, 1'($urandom), $urandom,
                  ($urandom % 3) != 0, ($urandom % 3) != 0);
            rst = 1'b0;
        end
        drain();
        check("random_q0_empty", q0.size(), 0);
        check("random_q1_empty", q1.size(), 0);

`ifdef STREAM_DEMUX_STATS_EN
        // Stats: counters wrap and clear on reset
        rst = 1'b1;
        drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
        rst = 1'b0;
        for (int i = 0; i < 17; i++) drive(1'b1, 1'b1, $urandom, 1'b1, 1'b1);
        drain();
        check("stats_out1_wrap", {60'b0, out1_cnt}, 64'd1);
        check("stats_out0_zero", {60'b0, out0_cnt}, 64'd0);
        for (int i = 0; i < 5; i++) drive(1'b1, 1'(i % 2), $urandom, 1'b1, 1'b1);
        rst = 1'b1;
        drive(1'b1, 1'b0, $urandom, 1'b1, 1'b1);
        rst = 1'b0;
        check("stats_rst_out0", {60'b0, out0_cnt}, 64'd0);
        check("stats_rst_out1", {60'b0, out1_cnt}, 64'd0);
        drain();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
